tensor_reader: RTL and testbench
================================

Name: tensor_reader

Overview:
- Read-side sequencer for a 2-D parameter tensor store, which has registered writes and a combinational read selected by seli/selj.
- On start, the block sweeps every element and drives the store's select lines.
- It captures each combinational param_out into an output register and emits the elements as a valid/ready stream to the RNN MAC datapath, with row-end and matrix-end markers.
- The store's write enable and the select mux are arbitrated upstream; while busy=1 the reader owns seli/selj.

Parameters:
ROWS, 2, number of matrix rows (element count, not index width)
COLS, 4, number of matrix columns
ROW_W, max(1,$clog2(ROWS)), seli width (derived)
COL_W, max(1,$clog2(COLS)), selj width (derived)

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
start  input  1  single-cycle request to begin a sweep; ignored while busy
abort  input  1  synchronous cancel of the sweep in progress
param_in  input  16  store read data for the current seli/selj, combinational
seli  output  ROW_W  row select to the store
selj  output  COL_W  column select to the store
m_data  output  16  stream data
m_valid  output  1  stream data valid
m_ready  input  1  downstream accept
m_row_last  output  1  element is the last of its line
m_last  output  1  element is the last of the matrix
busy  output  1  sweep in progress
done  output  1  one-cycle pulse after the final element is accepted

Behaviour:
- Reset (async, rst_n=0): state IDLE; seli=0, selj=0, m_data=0, m_valid=0, m_row_last=0, m_last=0, busy=0, done=0.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - seli/selj held at 0.
  - start=1 -> RUN and busy=1 from the next cycle.
- RUN:
  - "Load" occurs in any cycle where (!m_valid || m_ready).
  - On a load: m_data<=param_in, m_valid<=1, m_row_last/m_last <= position flags of the current (seli,selj), then the counters advance.
  - Row-major order: selj increments; on selj==COLS-1 it wraps to 0 and seli increments.
  - Loading (ROWS-1, COLS-1) sets m_last=1 and transitions to DRAIN; the counters wrap to 0.
  - No load -> counters, m_data and flags hold.
- DRAIN:
  - No further loads.
  - On m_valid&&m_ready: m_valid<=0, done<=1 for one cycle, busy<=0, state IDLE.
- Stream rules:
  - m_data, m_valid and the flags are stable while m_valid=1 and m_ready=0.
  - Handshake = m_valid&&m_ready.
  - Throughput is 1 element/cycle with m_ready tied high.
- Latency: start at cycle T -> seli/selj=(0,0) in T+1 -> first m_valid=1 in T+2. Total sweep with no backpressure: ROWS*COLS+1 cycles from start to the last handshake; done in the following cycle.
- Flags: m_row_last=1 when selj==COLS-1 at load; m_last=1 only on the final element. Both are cleared when m_valid drops.
- The store contents are sampled at the select cycle. Writes to the store during a sweep are undefined usage.
- abort=1 (any state, has priority over start and handshake):
  - next cycle: IDLE, m_valid=0, flags=0, seli=selj=0, busy=0, done=0.
  - Any pending element is discarded.
- start in the same cycle as done: ignored; start must be re-issued from IDLE.
- ROWS=1 or COLS=1 are legal: every element is row_last when COLS=1.
- Reset mid-sweep: immediate return to the reset values above.

Optional Feature:
- Macro: TENSOR_READER_COLMAJOR_EN.
- Defined:
  - Column-major traversal: seli increments fastest; on seli==ROWS-1 it wraps and selj increments.
  - m_row_last marks the end of a column (seli==ROWS-1).
  - m_last is still set at (ROWS-1, COLS-1).
  - Used to stream a transposed weight matrix.
- Undefined: row-major order as in Behaviour.
- Ports and latency are identical in both builds.

Test Plan:
- Store preloaded with 16'h0100 + 16*i + j (ROWS=2, COLS=4), m_ready=1, start pulse -> m_data sequence 0100,0101,0102,0103,0110,0111,0112,0113 on consecutive cycles starting T+2; m_row_last on 0103 and 0113; m_last on 0113; done at T+10; busy low at T+10.
- Same matrix, m_ready toggled 1,0,0,1,... -> identical sequence, no drops or duplicates; m_data held stable while m_ready=0.
- Issue start while busy -> ignored; sequence unaffected; exactly one done pulse.
- abort asserted while m_data=0111 is pending with m_ready=0 -> next cycle m_valid=0, busy=0, seli=selj=0, no done; a subsequent start replays from 0100.
- rst_n pulled low mid-sweep, asynchronously between clock edges -> all outputs at reset values immediately; after release, start produces the full sequence.
- Build with TENSOR_READER_COLMAJOR_EN -> sequence 0100,0110,0101,0111,0102,0112,0103,0113; m_row_last on every second element; m_last on 0113.

Source files
------------

// File: rtl/tensor_reader.sv
// Read-side sequencer for a 2-D parameter store: sweeps seli/selj and streams each element
// over valid/ready with row-end and matrix-end markers. Define TENSOR_READER_COLMAJOR_EN for column-major order.
`timescale 1ns/1ps
module tensor_reader #(
    parameter int ROWS  = 2,
    parameter int COLS  = 4,
    parameter int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1,
    parameter int COL_W = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [15:0]      param_in,
    output logic [ROW_W-1:0] seli,
    output logic [COL_W-1:0] selj,
    output logic [15:0]      m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_row_last,
    output logic             m_last,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [ROW_W-1:0] ROW_MAX  = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_MAX  = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_ZERO = {ROW_W{1'b0}};
    localparam logic [COL_W-1:0] COL_ZERO = {COL_W{1'b0}};

    state_t           r_state;
    logic [ROW_W-1:0] r_i;
    logic [COL_W-1:0] r_j;
    logic [15:0]      r_data;
    logic             r_valid;
    logic             r_row_last;
    logic             r_last;
    logic             r_busy;
    logic             r_done;

    logic [ROW_W-1:0] w_i_next;
    logic [COL_W-1:0] w_j_next;
    logic             w_row_last;
    logic             w_last;
    logic             w_load;

    assign w_load = !r_valid || m_ready;
    assign w_last = (r_i == ROW_MAX) && (r_j == COL_MAX);

    // Next select position and line-end flag for the element currently addressed
    always_comb begin
        w_i_next   = r_i;
        w_j_next   = r_j;
        w_row_last = 1'b0;
`ifdef TENSOR_READER_COLMAJOR_EN
        w_row_last = (r_i == ROW_MAX);
        if (r_i == ROW_MAX) begin
            w_i_next = ROW_ZERO;
            if (r_j == COL_MAX) begin
                w_j_next = COL_ZERO;
            end else begin
                w_j_next = r_j + COL_W'(1);
            end
        end else begin
            w_i_next = r_i + ROW_W'(1);
        end
`else
        w_row_last = (r_j == COL_MAX);
        if (r_j == COL_MAX) begin
            w_j_next = COL_ZERO;
            if (r_i == ROW_MAX) begin
                w_i_next = ROW_ZERO;
            end else begin
                w_i_next = r_i + ROW_W'(1);
            end
        end else begin
            w_j_next = r_j + COL_W'(1);
        end
`endif
    end

    // Sweep FSM with registered stream, select and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_i        <= ROW_ZERO;
            r_j        <= COL_ZERO;
            r_data     <= 16'h0000;
            r_valid    <= 1'b0;
            r_row_last <= 1'b0;
            r_last     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else if (abort) begin
            r_state    <= ST_IDLE;
            r_i        <= ROW_ZERO;
            r_j        <= COL_ZERO;
            r_valid    <= 1'b0;
            r_row_last <= 1'b0;
            r_last     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_i <= ROW_ZERO;
                    r_j <= COL_ZERO;
                    // a start coinciding with the done pulse must be re-issued
                    if (start && !r_done) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_load) begin
                        r_data     <= param_in;
                        r_valid    <= 1'b1;
                        r_row_last <= w_row_last;
                        r_last     <= w_last;
                        r_i        <= w_i_next;
                        r_j        <= w_j_next;
                        if (w_last) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (r_valid && m_ready) begin
                        r_valid    <= 1'b0;
                        r_row_last <= 1'b0;
                        r_last     <= 1'b0;
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_i        <= ROW_ZERO;
                    r_j        <= COL_ZERO;
                    r_valid    <= 1'b0;
                    r_row_last <= 1'b0;
                    r_last     <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign seli       = r_i;
    assign selj       = r_j;
    assign m_data     = r_data;
    assign m_valid    = r_valid;
    assign m_row_last = r_row_last;
    assign m_last     = r_last;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_tensor_reader.sv
// Scoreboard bench for tensor_reader: a reference sweep model fills an expectation queue,
// and a negedge monitor pops and compares on every handshake.
`timescale 1ns/1ps
module tb_tensor_reader;
    localparam int ROWS  = 2;
    localparam int COLS  = 4;
    localparam int N     = ROWS * COLS;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
`ifdef TENSOR_READER_COLMAJOR_EN
    localparam bit COLMAJ = 1'b1;
`else
    localparam bit COLMAJ = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             m_ready = 1'b0;
    logic [15:0]      param_in;
    logic [ROW_W-1:0] seli;
    logic [COL_W-1:0] selj;
    logic [15:0]      m_data;
    logic             m_valid, m_row_last, m_last, busy, done;

    logic [15:0] mem [ROWS][COLS];

    typedef struct packed {
        logic [15:0] d;
        logic        rl;
        logic        l;
    } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int rdy_mode = 0;
    bit rst_evt = 1'b0;

    tensor_reader #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .param_in(param_in),
        .seli(seli), .selj(selj), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_row_last(m_row_last), .m_last(m_last), .busy(busy), .done(done)
    );

    assign param_in = mem[seli][selj];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge rst_n) rst_evt = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic load_mem(input bit rnd);
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++)
                mem[ROW_W'(i)][COL_W'(j)] = rnd ? 16'($urandom) : 16'h0100 + 16'(16 * i + j);
    endtask

    // Reference: element k of the sweep, from plain index arithmetic
    task automatic push_expected();
        exp_t e;
        int   i, j;
        for (int k = 0; k < N; k++) begin
            if (COLMAJ) begin i = k % ROWS; j = k / ROWS; end
            else        begin i = k / COLS; j = k % COLS; end
            e.d  = mem[ROW_W'(i)][COL_W'(j)];
            e.rl = COLMAJ ? (i == ROWS - 1) : (j == COLS - 1);
            e.l  = (k == N - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic pulse_start(output int c0);
        start = 1'b1;
        c0 = cyc;
        push_expected();
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int c0, input bit timed, input bit inject, input bit start_at_done);
        for (int n = 0; n < 200; n++) begin
            if (done) break;
            @(posedge clk); #1;
            start = (inject && n == 2);
        end
        start = 1'b0;
        if (!done) begin
            n_checks++; n_errors++;
            $display("FAIL done_timeout actual=0 required=1");
        end else begin
            if (timed) chk("done_cycle", cyc, c0 + 10);
            chk("busy_at_done", busy, 0);
            chk("queue_drained", exp_q.size(), 0);
            if (start_at_done) begin
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
                chk("start_at_done_ignored", busy, 0);
                chk("start_at_done_no_valid", m_valid, 0);
            end
        end
    endtask

    // Downstream ready pattern: 0 always, 1 repeating 1,0,0, 2 random, 3 manual
    initial begin : ready_drv
        int ph;
        ph = 0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: m_ready = 1'b1;
                1: begin m_ready = (ph == 0); ph = (ph + 1) % 3; end
                2: m_ready = ($urandom_range(0, 3) != 0);
                default: ;
            endcase
        end
    end

    // Scoreboard monitor: handshakes, hold-while-stalled, done one cycle after final element
    initial begin : monitor
        logic        prev_stall, prev_abort, prev_last_hs;
        logic [15:0] held;
        exp_t        e;
        prev_stall = 1'b0; prev_abort = 1'b0; prev_last_hs = 1'b0; held = 16'h0000;
        forever begin
            @(negedge clk);
            if (rst_evt || !rst_n) begin
                rst_evt = 1'b0;
                prev_stall = 1'b0; prev_abort = 1'b0; prev_last_hs = 1'b0;
            end else begin
                chk("done_pulse", done, prev_last_hs);
                if (prev_stall && !prev_abort) begin
                    chk("hold_valid", m_valid, 1);
                    chk("hold_data", m_data, held);
                end
                if (m_valid && m_ready && !abort) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_errors++;
                        $display("FAIL unexpected_elem actual=%h required=none", m_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (m_data !== e.d || m_row_last !== e.rl || m_last !== e.l) begin
                            n_errors++;
                            $display("FAIL elem actual=%h/rl%b/l%b required=%h/rl%b/l%b",
                                     m_data, m_row_last, m_last, e.d, e.rl, e.l);
                        end
                    end
                end
                prev_stall   = m_valid && !m_ready;
                prev_abort   = abort;
                held         = m_data;
                prev_last_hs = m_valid && m_ready && !abort && m_last;
            end
        end
    end

    initial begin : stim
        int c0;
        load_mem(1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", m_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sel", {seli, selj}, 0);
        chk("rst_flags", {m_row_last, m_last, done}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // No backpressure: latency and throughput on the reference matrix
        rdy_mode = 0;
        pulse_start(c0);
        chk("t1_busy", busy, 1);
        chk("t1_sel", {seli, selj}, 0);
        chk("t1_valid", m_valid, 0);
        @(posedge clk); #1;
        chk("t2_valid", m_valid, 1);
        chk("t2_data", m_data, 16'h0100);
        wait_done(c0, 1'b1, 1'b0, 1'b0);

        // 1,0,0 backpressure with a start issued while busy
        rdy_mode = 1;
        pulse_start(c0);
        wait_done(c0, 1'b0, 1'b1, 1'b1);

        // Abort while element 0111 is stalled
        rdy_mode = 3;
        m_ready  = 1'b1;
        pulse_start(c0);
        for (int n = 0; n < 20; n++) begin
            if (m_valid && m_data == 16'h0111) break;
            @(posedge clk); #1;
        end
        chk("abort_target", m_data, 16'h0111);
        m_ready = 1'b0;
        @(posedge clk); #1;
        chk("abort_stall_data", m_data, 16'h0111);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        exp_q.delete();
        chk("abort_valid", m_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_sel", {seli, selj}, 0);
        chk("abort_flags", {m_row_last, m_last, done}, 0);
        @(posedge clk); #1;
        chk("abort_no_done", done, 0);
        rdy_mode = 0;
        pulse_start(c0);
        @(posedge clk); #1;
        chk("replay_first", m_data, 16'h0100);
        wait_done(c0, 1'b1, 1'b0, 1'b0);

        // Randomized matrices and ready patterns
        for (int s = 0; s < 6; s++) begin
            load_mem(1'b1);
            rdy_mode = s % 3;
            @(posedge clk); #1;
            pulse_start(c0);
            wait_done(c0, rdy_mode == 0, s == 4, s == 5);
        end

        // Asynchronous reset mid-sweep
        rdy_mode = 2;
        pulse_start(c0);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", m_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_sel", {seli, selj}, 0);
        chk("arst_data", m_data, 0);
        chk("arst_flags", {m_row_last, m_last, done}, 0);
        exp_q.delete();
        #1 rst_n = 1'b1;
        rdy_mode = 0;
        load_mem(1'b0);
        @(posedge clk); #1;
        pulse_start(c0);
        @(posedge clk); #1;
        chk("post_rst_first", m_data, 16'h0100);
        wait_done(c0, 1'b1, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
